pwm_ctrl: RTL and testbench
===========================

// Module: pwm_ctrl
// PURPOSE
//  Multi-channel PWM controller behind the gpmc_sync register interface. It decodes host
//  read/write strobes into per-channel shadow registers and schedules atomic commits of
//  shadow->active settings at each channel's period boundary, so the outputs never glitch.
//  Sits between gpmc_sync and the pmod pins; replaces ad-hoc mem[] decoding in top.
// PARAMETERS
//  N_CH        4   number of PWM channels; N_CH*4 <= 2**ADDR_WIDTH
//  ADDR_WIDTH  4   host word-address width, matches gpmc_sync
//  DATA_WIDTH  16  host data width; also the width of the period, duty and counter
// PORTS
//  clk       in   1            system clock; the only clock
//  rst_n     in   1            synchronous reset, active low
//  cs        in   1            from gpmc_sync, active low
//  we        in   1            from gpmc_sync, active low
//  oe        in   1            from gpmc_sync, active low
//  address   in   ADDR_WIDTH   word address
//  data_out  in   DATA_WIDTH   host write data (gpmc_sync naming)
//  data_in   out  DATA_WIDTH   host read data
//  pwm_out   out  N_CH         PWM outputs
//  commit_pl out  N_CH         1-cycle pulse when a channel loads its shadow values
// BEHAVIOUR
//  - Reset: all shadow/active regs 0, pending 0, counters 0, state IDLE, data_in 0,
//    pwm_out 0, commit_pl 0.
//  - Write strobe: cs=0, we=0, oe=1. Read strobe: cs=0, we=1, oe=0. Evaluated every clk.
//    A strobe held N cycles acts N times; repeated writes are idempotent.
//  - Map: ch = address[ADDR_WIDTH-1:2], reg = address[1:0]; ch >= N_CH -> write ignored,
//    read returns 0.
//    reg0 CTRL  [0]=EN [1]=POL [2]=COMMIT (write-only, reads as 0), others reserved, read 0
//    reg1 PERIOD shadow   reg2 DUTY shadow
//    reg3 STATUS read-only [0]=PENDING [1]=RUNNING; writes ignored
//  - Read latency 1: data_in is registered from the address seen on the strobe cycle.
//    data_in is 0 in any cycle following a non-read cycle. Reads return shadow values.
//  - Writing CTRL with COMMIT=1 sets PENDING. Writing while PENDING=1 is allowed: the
//    shadow contents at consume time are committed.
//  - pwm_channel FSM per channel:
//    IDLE: cnt=0, pwm_out=active POL. PENDING -> load active, clear PENDING,
//          pulse commit_pl; go RUN next cycle if loaded EN=1 and PERIOD!=0.
//    RUN:  cnt counts 0..PERIOD-1 and wraps. Wrap cycle (cnt==PERIOD-1) with
//          PENDING -> load, clear, pulse; cnt restarts at 0. If loaded EN=0 or
//          PERIOD=0 -> IDLE.
//  - Output in RUN is registered: pwm_out = (cnt < DUTY) ^ POL. DUTY >= PERIOD gives a
//    constant active level; DUTY=0 gives a constant inactive level.
//  - A COMMIT write in the same cycle as a wrap is not consumed at that wrap; it is
//    consumed at the next wrap, or next cycle if IDLE.
//  - In IDLE a commit is taken on the cycle after the COMMIT write.
//  - Arithmetic is unsigned DATA_WIDTH; the counter never exceeds PERIOD-1.
//  - rst_n low in any state -> reset values next edge; pending commits are discarded.
// STRUCTURE
//  - pwm_ctrl_pkg: register offsets (REG_CTRL..REG_STATUS), CTRL/STATUS bit indices,
//    and the state enum {IDLE, RUN}.
//  - Sub-module pwm_channel: shadow-to-active load, counter, FSM, output register.
//    Instantiated N_CH times via generate.
//  - pwm_ctrl holds the shadow registers, PENDING flags, address decode and read mux.
// TESTING
//  - Reset: rst_n=0 mid-RUN with PENDING=1 -> all outputs 0, STATUS reads 0, no
//    commit_pl pulse.
//  - ch0 PERIOD=10, DUTY=3, CTRL=0x5 -> commit_pl[0] pulses, then pwm_out[0] is high
//    3 cycles and low 7 cycles, repeating.
//  - While running, set DUTY=7 and COMMIT -> old waveform holds until wrap; commit_pl
//    at cnt==9; next period is high 7 cycles; STATUS.PENDING is 1 until then.
//  - COMMIT write on the wrap cycle -> PENDING stays 1 for one full period and is
//    consumed at the following wrap.
//  - Edge cases: DUTY=12, PERIOD=10 -> constant 1. POL=1, DUTY=0 -> constant 1.
//    PERIOD=0 with EN=1 -> stays IDLE, output = POL.
//  - Reads: read addr 2 -> DUTY value on data_in 1 cycle later, 0 afterwards; read addr 3
//    during PENDING -> 0x3; ch >= N_CH address -> 0.

Source files
------------

// File: rtl/pwm_ctrl_pkg.sv
// pwm_ctrl_pkg: register map, bit positions and channel FSM states shared by the PWM controller
package pwm_ctrl_pkg;

    localparam logic [1:0] REG_CTRL   = 2'd0;
    localparam logic [1:0] REG_PERIOD = 2'd1;
    localparam logic [1:0] REG_DUTY   = 2'd2;
    localparam logic [1:0] REG_STATUS = 2'd3;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_POL    = 1;
    localparam int CTRL_COMMIT = 2;

    localparam int ST_PENDING = 0;
    localparam int ST_RUNNING = 1;

    typedef enum logic {IDLE, RUN} state_e;

    // COMMIT is write-only, so only EN and POL are visible on a CTRL read
    function automatic logic [2:0] ctrl_bits(input logic en, input logic pol);
        logic [2:0] c;
        c = '0;
        c[CTRL_EN] = en;
        c[CTRL_POL] = pol;
        return c;
    endfunction

    function automatic logic [1:0] status_bits(input logic pending, input logic running);
        logic [1:0] s;
        s = '0;
        s[ST_PENDING] = pending;
        s[ST_RUNNING] = running;
        return s;
    endfunction

endpackage

// File: rtl/pwm_ctrl_channel.sv
// pwm_channel: one PWM channel that swaps in shadow settings only at a period boundary
module pwm_channel
    import pwm_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  pending,
    input  logic                  sh_en,
    input  logic                  sh_pol,
    input  logic [DATA_WIDTH-1:0] sh_period,
    input  logic [DATA_WIDTH-1:0] sh_duty,
    output logic                  pwm_out,
    output logic                  commit_pl,
    output logic                  running
);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] cnt_q, cnt_d, period_q, period_d, duty_q, duty_d;
    logic                  en_q, en_d, pol_q, pol_d, pwm_q, pwm_d;
    logic                  wrap, load, go;

    // Load when idle or on the wrap cycle; output is computed from the next count so it stays registered
    always_comb begin
        wrap = cnt_q == period_q - DATA_WIDTH'(1);
        load = rst_n && pending && (state_q == IDLE || wrap);
        en_d = load ? sh_en : en_q;
        pol_d = load ? sh_pol : pol_q;
        period_d = load ? sh_period : period_q;
        duty_d = load ? sh_duty : duty_q;
        go = en_d && period_d != '0;
        state_d = (state_q == RUN && !load) || (load && go) ? RUN : IDLE;
        cnt_d = state_q == RUN && !wrap ? cnt_q + DATA_WIDTH'(1) : '0;
        pwm_d = state_d == RUN ? (cnt_d < duty_d) ^ pol_d : pol_d;
    end

    // Channel state; reset throws away the active settings
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q <= '0;
            period_q <= '0;
            duty_q <= '0;
            en_q <= 1'b0;
            pol_q <= 1'b0;
            pwm_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            period_q <= period_d;
            duty_q <= duty_d;
            en_q <= en_d;
            pol_q <= pol_d;
            pwm_q <= pwm_d;
        end
    end

    assign pwm_out = pwm_q;
    assign commit_pl = load;
    assign running = state_q == RUN;

endmodule

// File: rtl/pwm_ctrl.sv
// pwm_ctrl: host register decode, shadow registers and commit scheduling for N_CH PWM channels
module pwm_ctrl
    import pwm_ctrl_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cs,
    input  logic                  we,
    input  logic                  oe,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [DATA_WIDTH-1:0] data_out,
    output logic [DATA_WIDTH-1:0] data_in,
    output logic [N_CH-1:0]       pwm_out,
    output logic [N_CH-1:0]       commit_pl
);

    localparam int CW = ADDR_WIDTH - 2;

    logic                  wr, rd;
    logic [CW-1:0]         ch;
    logic [1:0]            rg;
    logic [N_CH-1:0]       hit, running;
    logic [N_CH-1:0]       en_q, en_d, pol_q, pol_d, pend_q, pend_d;
    logic [DATA_WIDTH-1:0] period_q [N_CH];
    logic [DATA_WIDTH-1:0] period_d [N_CH];
    logic [DATA_WIDTH-1:0] duty_q [N_CH];
    logic [DATA_WIDTH-1:0] duty_d [N_CH];
    logic [DATA_WIDTH-1:0] data_in_q, data_in_d, rd_val;

    assign wr = !cs && !we && oe;
    assign rd = !cs && we && !oe;
    assign ch = address[ADDR_WIDTH-1:2];
    assign rg = address[1:0];

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        assign hit[i] = ch == CW'(i);
        pwm_channel #(.DATA_WIDTH(DATA_WIDTH)) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .pending   (pend_q[i]),
            .sh_en     (en_q[i]),
            .sh_pol    (pol_q[i]),
            .sh_period (period_q[i]),
            .sh_duty   (duty_q[i]),
            .pwm_out   (pwm_out[i]),
            .commit_pl (commit_pl[i]),
            .running   (running[i])
        );
    end

    // Shadow writes and read mux; a COMMIT landing on a consume cycle wins so it waits for the next boundary
    always_comb begin
        en_d = en_q;
        pol_d = pol_q;
        period_d = period_q;
        duty_d = duty_q;
        pend_d = pend_q & ~commit_pl;
        rd_val = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (wr && hit[i] && rg == REG_CTRL) begin
                en_d[i] = data_out[CTRL_EN];
                pol_d[i] = data_out[CTRL_POL];
                pend_d[i] = pend_d[i] | data_out[CTRL_COMMIT];
            end
            if (wr && hit[i] && rg == REG_PERIOD) period_d[i] = data_out;
            if (wr && hit[i] && rg == REG_DUTY) duty_d[i] = data_out;
            if (hit[i]) rd_val = rg == REG_CTRL   ? DATA_WIDTH'(ctrl_bits(en_q[i], pol_q[i])) :
                                 rg == REG_PERIOD ? period_q[i] :
                                 rg == REG_DUTY   ? duty_q[i] :
                                                    DATA_WIDTH'(status_bits(pend_q[i], running[i]));
        end
        data_in_d = rd ? rd_val : '0;
    end

    // Host-visible registers; reset discards any pending commits
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            en_q <= '0;
            pol_q <= '0;
            pend_q <= '0;
            period_q <= '{default: '0};
            duty_q <= '{default: '0};
            data_in_q <= '0;
        end else begin
            en_q <= en_d;
            pol_q <= pol_d;
            pend_q <= pend_d;
            period_q <= period_d;
            duty_q <= duty_d;
            data_in_q <= data_in_d;
        end
    end

    assign data_in = data_in_q;

endmodule

// File: tb/tb_pwm_ctrl.sv
// tb_pwm_ctrl: directed stimulus with queued expectations checked by an independent monitor
module tb_pwm_ctrl;

    localparam int N = 3, AW = 4, DW = 16;

    logic          clk = 1'b0, rst_n = 1'b0, cs = 1'b1, we = 1'b1, oe = 1'b1;
    logic [AW-1:0] address = '0;
    logic [DW-1:0] data_out = '0;
    logic [DW-1:0] data_in;
    logic [N-1:0]  pwm_out, commit_pl;
    int            cyc = 0, checks = 0, errors = 0, t = 0, s = 0;
    logic          rd_seen = 1'b0;

    typedef struct { int cyc; logic v; } pwm_t;
    typedef struct { int cyc; logic [N-1:0] mask; } com_t;
    typedef struct { logic [AW-1:0] addr; logic [DW-1:0] val; } rd_t;

    pwm_t pwm_q [$];
    com_t com_q [$];
    rd_t  rd_q [$];
    pwm_t p;
    com_t c;
    rd_t  r;

    pwm_ctrl #(.N_CH(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .cs        (cs),
        .we        (we),
        .oe        (oe),
        .address   (address),
        .data_out  (data_out),
        .data_in   (data_in),
        .pwm_out   (pwm_out),
        .commit_pl (commit_pl)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        rd_seen <= !cs && we && !oe;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: compares whatever the DUT presents against the queued expectations
    always @(negedge clk) begin
        if (rd_seen) begin
            if (rd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_extra cyc=%0d got=%0h want=none", cyc, data_in);
            end else begin
                r = rd_q.pop_front();
                chk($sformatf("rd_addr_%0h", r.addr), 32'(data_in), 32'(r.val));
            end
        end else chk("rd_idle_zero", 32'(data_in), 32'd0);
        chk("pwm_unused_ch", 32'(pwm_out[N-1:1]), 32'd0);
        while (pwm_q.size() != 0 && pwm_q[0].cyc < cyc) begin
            p = pwm_q.pop_front();
            chk("pwm0_stale", 32'(p.cyc), 32'(cyc));
        end
        if (pwm_q.size() != 0 && pwm_q[0].cyc == cyc) begin
            p = pwm_q.pop_front();
            chk("pwm0", 32'(pwm_out[0]), 32'(p.v));
        end
        if (com_q.size() != 0 && com_q[0].cyc < cyc) begin
            c = com_q.pop_front();
            chk("commit_missed_at", 32'(cyc), 32'(c.cyc));
        end
        if (commit_pl != '0) begin
            if (com_q.size() != 0 && com_q[0].cyc == cyc) begin
                c = com_q.pop_front();
                chk("commit_mask", 32'(commit_pl), 32'(c.mask));
            end else begin
                checks++;
                errors++;
                $display("FAIL commit_extra cyc=%0d got=%0h want=0", cyc, commit_pl);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at(input int n);
        while (cyc < n) tick();
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        cs = 1'b0; we = 1'b0; oe = 1'b1; address = a; data_out = d;
        tick();
        cs = 1'b1; we = 1'b1;
    endtask

    task automatic rd(input logic [AW-1:0] a, input logic [DW-1:0] exp);
        rd_q.push_back('{a, exp});
        cs = 1'b0; we = 1'b1; oe = 1'b0; address = a;
        tick();
        cs = 1'b1; oe = 1'b1;
    endtask

    task automatic exp_pwm(input int from, input int n, input logic v);
        for (int i = 0; i < n; i++) pwm_q.push_back('{from + i, v});
    endtask

    // One PERIOD=10 window with the given duty, POL=0
    task automatic exp_per(input int from, input int duty);
        exp_pwm(from, duty, 1'b1);
        exp_pwm(from + duty, 10 - duty, 1'b0);
    endtask

    initial begin
        exp_pwm(1, 5, 1'b0);
        tick(); tick();
        rst_n = 1'b1;
        rd(4'h3, 16'h0);
        rd(4'h4, 16'h0);
        at(8);
        wr(4'h1, 16'd10);
        wr(4'h2, 16'd3);
        rd(4'h2, 16'd3);
        t = 12;
        at(t);
        com_q.push_back('{t + 1, 3'b001});
        exp_pwm(t + 1, 1, 1'b0);
        exp_per(t + 2, 3);
        exp_per(t + 12, 3);
        wr(4'h0, 16'h5);
        rd(4'h3, 16'h1);
        rd(4'h3, 16'h2);
        at(t + 14);
        wr(4'h2, 16'd7);
        com_q.push_back('{t + 21, 3'b001});
        exp_per(t + 22, 7);
        wr(4'h0, 16'h5);
        at(t + 17);
        rd(4'h3, 16'h3);
        at(t + 22);
        rd(4'h3, 16'h2);
        at(t + 29);
        wr(4'h2, 16'd5);
        exp_per(t + 32, 7);
        exp_per(t + 42, 5);
        com_q.push_back('{t + 41, 3'b001});
        at(t + 31);
        wr(4'h0, 16'h5);
        at(t + 35);
        rd(4'h3, 16'h3);
        at(t + 40);
        rd(4'h3, 16'h3);
        at(t + 42);
        rd(4'h3, 16'h2);
        wr(4'h2, 16'd12);
        exp_pwm(t + 52, 10, 1'b1);
        com_q.push_back('{t + 51, 3'b001});
        wr(4'h0, 16'h5);
        at(t + 53);
        wr(4'h2, 16'd0);
        exp_pwm(t + 62, 10, 1'b1);
        com_q.push_back('{t + 61, 3'b001});
        wr(4'h0, 16'h7);
        at(t + 63);
        wr(4'h1, 16'd0);
        exp_pwm(t + 72, 4, 1'b0);
        com_q.push_back('{t + 71, 3'b001});
        wr(4'h0, 16'h5);
        at(t + 73);
        rd(4'h3, 16'h0);
        rd(4'hE, 16'h0);
        rd(4'h0, 16'h1);
        rd(4'h1, 16'h0);
        wr(4'hC, 16'h5);
        wr(4'hE, 16'd9);
        rd(4'hE, 16'h0);
        rd(4'h6, 16'h0);
        s = t + 85;
        at(s);
        wr(4'h2, 16'd6);
        wr(4'h1, 16'd10);
        com_q.push_back('{s + 3, 3'b001});
        exp_pwm(s + 3, 1, 1'b0);
        exp_pwm(s + 4, 5, 1'b1);
        exp_pwm(s + 9, 6, 1'b0);
        wr(4'h0, 16'h5);
        at(s + 6);
        wr(4'h0, 16'h5);
        at(s + 8);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        at(s + 10);
        rd(4'h3, 16'h0);
        rd(4'h2, 16'h0);
        rd(4'h0, 16'h0);
        at(s + 20);
        chk("pwm_queue_left", 32'(pwm_q.size()), 32'd0);
        chk("commit_queue_left", 32'(com_q.size()), 32'd0);
        chk("rd_queue_left", 32'(rd_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1);
    end

endmodule
